// File: rtl/ipr1_trig_ctrl.sv
// ---------------------------------------------------------------------------
// ipr1_trig_ctrl
//
// Purpose: event trigger controller sitting between the frame datapath and
// the host. It watches the per-frame trigger from the datapath. After it has
// seen confirm_n consecutive hit frames it fires an event. A fire latches the
// centre-of-gravity location, counts the event and raises a level interrupt.
// A configurable holdoff then ignores the frames that follow. The block also
// shadows the host sensitivity and threshold values so that the datapath
// only sees changes at frame boundaries.
//
// Optional feature: define IPR1_TRIG_ROI_EN to qualify hits with a
// region-of-interest window. The window bounds are strict and are given by
// ROI_X1..ROI_Y2.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   frame_valid    datapath frame strobe; its falling edge marks end-of-frame
//   trig_in        datapath per-frame trigger, sampled at end-of-frame
//   cogx_i/cogy_i  datapath centre of gravity
//   arm/disarm     one-cycle host requests
//   confirm_n      consecutive hit frames needed to fire
//   holdoff_n      frames ignored after a fire
//   sens_cfg       host sensitivity
//   thr_cfg        host threshold
//   irq_ack        interrupt acknowledge
//   sensitivity_o  shadowed sensitivity to the datapath
//   threshold_o    shadowed threshold to the datapath
//   irq            event interrupt (level)
//   ovr            sticky overrun (fire while irq still pending)
//   state_o        FSM state: 0 IDLE, 1 ARMED, 2 CONFIRM, 3 HOLDOFF
//   evt_cogx/evt_cogy  location latched at the last fire
//   evt_count      saturating count of fired events
// ---------------------------------------------------------------------------
module ipr1_trig_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ROI_X1 = 16,
    parameter int ROI_X2 = 48,
    parameter int ROI_Y1 = 16,
    parameter int ROI_Y2 = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_valid,
    input  logic             trig_in,
    input  logic [7:0]       cogx_i,
    input  logic [7:0]       cogy_i,
    input  logic             arm,
    input  logic             disarm,
    input  logic [3:0]       confirm_n,
    input  logic [7:0]       holdoff_n,
    input  logic [7:0]       sens_cfg,
    input  logic [15:0]      thr_cfg,
    input  logic             irq_ack,
    output logic [7:0]       sensitivity_o,
    output logic [15:0]      threshold_o,
    output logic             irq,
    output logic             ovr,
    output logic [1:0]       state_o,
    output logic [7:0]       evt_cogx,
    output logic [7:0]       evt_cogy,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [7:0] ROI_X1_B = ROI_X1[7:0];
    localparam logic [7:0] ROI_X2_B = ROI_X2[7:0];
    localparam logic [7:0] ROI_Y1_B = ROI_Y1[7:0];
    localparam logic [7:0] ROI_Y2_B = ROI_Y2[7:0];

    state_t           state_q, state_d;
    logic             fv_q;
    logic [3:0]       hit_cnt_q, hit_cnt_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             irq_q, irq_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       evt_cogx_q, evt_cogx_d;
    logic [7:0]       evt_cogy_q, evt_cogy_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic [7:0]       sens_q, sens_d;
    logic [15:0]      thr_q, thr_d;

    logic             eof;
    logic             in_roi;
    logic             hit;
    logic             fire;
    logic [4:0]       hit_cnt_inc;
    logic [7:0]       hold_cnt_dec;

    // End-of-frame is the falling edge of frame_valid. fv_q is cleared by
    // reset, so no eof is seen until frame_valid has been sampled high.
    assign eof = fv_q & ~frame_valid;

    assign in_roi = (cogx_i > ROI_X1_B) && (cogx_i < ROI_X2_B) &&
                    (cogy_i > ROI_Y1_B) && (cogy_i < ROI_Y2_B);

`ifdef IPR1_TRIG_ROI_EN
    assign hit = eof & trig_in & in_roi;
`else
    logic roi_unused;
    assign roi_unused = in_roi;
    assign hit = eof & trig_in;
`endif

    // Widened by one bit so the compare against confirm_n cannot wrap.
    assign hit_cnt_inc  = {1'b0, hit_cnt_q} + 5'd1;
    assign hold_cnt_dec = (hold_cnt_q == 8'd0) ? 8'd0 : hold_cnt_q - 8'd1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic, including the confirm and holdoff counters
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        fire       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hit) begin
                    hit_cnt_d = 4'd1;
                    if (confirm_n <= 4'd1) begin
                        fire = 1'b1;
                    end else begin
                        state_d = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                if (hit) begin
                    hit_cnt_d = hit_cnt_inc[3:0];
                    if (hit_cnt_inc >= {1'b0, confirm_n}) begin
                        fire = 1'b1;
                    end
                end else if (eof) begin
                    state_d   = ST_ARMED;
                    hit_cnt_d = 4'd0;
                end
            end
            ST_HOLDOFF: begin
                // trig_in is deliberately ignored here; only eof counts.
                if (eof) begin
                    hold_cnt_d = hold_cnt_dec;
                    if (hold_cnt_dec == 8'd0) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fire) begin
            hit_cnt_d = 4'd0;
            if (holdoff_n == 8'd0) begin
                state_d = ST_ARMED;
            end else begin
                state_d    = ST_HOLDOFF;
                hold_cnt_d = holdoff_n;
            end
        end

        // Disarm overrides everything, including a fire in the same cycle.
        if (disarm) begin
            state_d    = ST_IDLE;
            hit_cnt_d  = 4'd0;
            hold_cnt_d = 8'd0;
            fire       = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output / event logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_o     = state_q;
        evt_cogx_d  = evt_cogx_q;
        evt_cogy_d  = evt_cogy_q;
        evt_count_d = evt_count_q;

        // A fire in the same cycle as an ack keeps irq set.
        irq_d = fire | (irq_q & ~irq_ack);
        // Overrun is set by a fire that finds irq pending, and is cleared
        // only by an ack that does not coincide with a fire.
        ovr_d = (fire & irq_q) | (ovr_q & ~(irq_ack & ~fire));

        if (fire) begin
            evt_cogx_d = cogx_i;
            evt_cogy_d = cogy_i;
            if (evt_count_q != {CNT_W{1'b1}}) begin
                evt_count_d = evt_count_q + 1'b1;
            end
        end

        // Shadow registers follow the host freely while idle and otherwise
        // only at frame boundaries.
        if ((state_q == ST_IDLE) || eof) begin
            sens_d = sens_cfg;
            thr_d  = thr_cfg;
        end else begin
            sens_d = sens_q;
            thr_d  = thr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_q        <= 1'b0;
            hit_cnt_q   <= 4'd0;
            hold_cnt_q  <= 8'd0;
            irq_q       <= 1'b0;
            ovr_q       <= 1'b0;
            evt_cogx_q  <= 8'd0;
            evt_cogy_q  <= 8'd0;
            evt_count_q <= '0;
            sens_q      <= 8'd0;
            thr_q       <= 16'd0;
        end else begin
            fv_q        <= frame_valid;
            hit_cnt_q   <= hit_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            irq_q       <= irq_d;
            ovr_q       <= ovr_d;
            evt_cogx_q  <= evt_cogx_d;
            evt_cogy_q  <= evt_cogy_d;
            evt_count_q <= evt_count_d;
            sens_q      <= sens_d;
            thr_q       <= thr_d;
        end
    end

    assign sensitivity_o = sens_q;
    assign threshold_o   = thr_q;
    assign irq           = irq_q;
    assign ovr           = ovr_q;
    assign evt_cogx      = evt_cogx_q;
    assign evt_cogy      = evt_cogy_q;
    assign evt_count     = evt_count_q;

endmodule

// File: tb/tb_ipr1_trig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ipr1_trig_ctrl
//
// Directed bench for ipr1_trig_ctrl. A table of per-frame records drives the
// main confirm / fire / holdoff / overrun flow. Hand-written sequences cover
// reset, shadow-register timing, disarm racing a hit, fire racing an ack,
// and reset in the middle of a confirm sequence.
// ---------------------------------------------------------------------------
module tb_ipr1_trig_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_valid;
    logic        trig_in;
    logic [7:0]  cogx_i, cogy_i;
    logic        arm, disarm;
    logic [3:0]  confirm_n;
    logic [7:0]  holdoff_n;
    logic [7:0]  sens_cfg;
    logic [15:0] thr_cfg;
    logic        irq_ack;
    logic [7:0]  sensitivity_o;
    logic [15:0] threshold_o;
    logic        irq, ovr;
    logic [1:0]  state_o;
    logic [7:0]  evt_cogx, evt_cogy;
    logic [15:0] evt_count;

    int checks = 0;
    int errors = 0;

    ipr1_trig_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_valid   (frame_valid),
        .trig_in       (trig_in),
        .cogx_i        (cogx_i),
        .cogy_i        (cogy_i),
        .arm           (arm),
        .disarm        (disarm),
        .confirm_n     (confirm_n),
        .holdoff_n     (holdoff_n),
        .sens_cfg      (sens_cfg),
        .thr_cfg       (thr_cfg),
        .irq_ack       (irq_ack),
        .sensitivity_o (sensitivity_o),
        .threshold_o   (threshold_o),
        .irq           (irq),
        .ovr           (ovr),
        .state_o       (state_o),
        .evt_cogx      (evt_cogx),
        .evt_cogy      (evt_cogy),
        .evt_count     (evt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack_before;
        logic        trig;
        logic [3:0]  conf;
        logic [7:0]  hold;
        logic [1:0]  exp_state;
        logic        exp_irq;
        logic        exp_ovr;
        logic [15:0] exp_count;
        logic [7:0]  exp_evtx;
        logic [7:0]  exp_evty;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: frame_valid high for two cycles, then the eof cycle with
    // trig_in presented. ack_eof drives irq_ack on the eof edge.
    task automatic frame(input logic trig, input logic ack_eof, input logic dis);
        frame_valid = 1'b1;
        tick();
        tick();
        frame_valid = 1'b0;
        trig_in     = trig;
        irq_ack     = ack_eof;
        disarm      = dis;
        tick();
        trig_in = 1'b0;
        irq_ack = 1'b0;
        disarm  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_valid = 1'b0;
        trig_in     = 1'b0;
        cogx_i      = 8'd0;
        cogy_i      = 8'd0;
        arm         = 1'b0;
        disarm      = 1'b0;
        confirm_n   = 4'd3;
        holdoff_n   = 8'd2;
        sens_cfg    = 8'h5A;
        thr_cfg     = 16'hAAAA;
        irq_ack     = 1'b0;

        // Records: ack_before, trig, conf, hold, state, irq, ovr, count, evtx, evty
        vecs[0]  = '{1'b0, 1'b1, 4'd3, 8'd2, 2'd2, 1'b0, 1'b0, 16'd0, 8'd0,  8'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd3, 8'd2, 2'd2, 1'b0, 1'b0, 16'd0, 8'd0,  8'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'd3, 8'd2, 2'd3, 1'b1, 1'b0, 16'd1, 8'd22, 8'd32};
        vecs[3]  = '{1'b0, 1'b1, 4'd1, 8'd2, 2'd3, 1'b1, 1'b0, 16'd1, 8'd22, 8'd32};
        vecs[4]  = '{1'b0, 1'b1, 4'd1, 8'd2, 2'd1, 1'b1, 1'b0, 16'd1, 8'd22, 8'd32};
        vecs[5]  = '{1'b0, 1'b1, 4'd1, 8'd2, 2'd3, 1'b1, 1'b1, 16'd2, 8'd25, 8'd35};
        vecs[6]  = '{1'b1, 1'b0, 4'd3, 8'd0, 2'd3, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[7]  = '{1'b0, 1'b0, 4'd3, 8'd0, 2'd1, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[8]  = '{1'b0, 1'b1, 4'd3, 8'd0, 2'd2, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[9]  = '{1'b0, 1'b1, 4'd3, 8'd0, 2'd2, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[10] = '{1'b0, 1'b0, 4'd3, 8'd0, 2'd1, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[11] = '{1'b0, 1'b1, 4'd3, 8'd0, 2'd2, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[12] = '{1'b0, 1'b1, 4'd3, 8'd0, 2'd2, 1'b0, 1'b0, 16'd2, 8'd25, 8'd35};
        vecs[13] = '{1'b0, 1'b1, 4'd3, 8'd0, 2'd1, 1'b1, 1'b0, 16'd3, 8'd33, 8'd43};
        vecs[14] = '{1'b1, 1'b1, 4'd1, 8'd0, 2'd1, 1'b1, 1'b0, 16'd4, 8'd34, 8'd44};

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_evtx", 32'(evt_cogx), 32'd0);
        chk("rst_sens", 32'(sensitivity_o), 32'd0);
        chk("rst_thr", 32'(threshold_o), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_sens_load", 32'(sensitivity_o), 32'h5A);
        chk("idle_thr_load", 32'(threshold_o), 32'hAAAA);

        // ---------------- table-driven main flow ----------------
        pulse_arm();
        chk("armed_state", 32'(state_o), 32'd1);
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].ack_before) begin
                irq_ack = 1'b1;
                tick();
                irq_ack = 1'b0;
                chk($sformatf("v%0d_ack_irq", i), 32'(irq), 32'd0);
                chk($sformatf("v%0d_ack_ovr", i), 32'(ovr), 32'd0);
            end
            confirm_n = vecs[i].conf;
            holdoff_n = vecs[i].hold;
            cogx_i    = 8'(20 + i);
            cogy_i    = 8'(30 + i);
            frame(vecs[i].trig, 1'b0, 1'b0);
            chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            chk($sformatf("v%0d_ovr", i), 32'(ovr), 32'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_count", i), 32'(evt_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_evtx", i), 32'(evt_cogx), 32'(vecs[i].exp_evtx));
            chk($sformatf("v%0d_evty", i), 32'(evt_cogy), 32'(vecs[i].exp_evty));
            $display("frame %0d trig=%0d conf=%0d hold=%0d -> state=%0d irq=%0d ovr=%0d count=%0d",
                     i, vecs[i].trig, vecs[i].conf, vecs[i].hold, state_o, irq, ovr, evt_count);
        end

        // ---------------- fire coinciding with ack ----------------
        confirm_n = 4'd1;
        holdoff_n = 8'd0;
        cogx_i    = 8'd40;
        cogy_i    = 8'd41;
        frame(1'b1, 1'b1, 1'b0);
        chk("fire_ack_irq", 32'(irq), 32'd1);
        chk("fire_ack_ovr", 32'(ovr), 32'd1);
        chk("fire_ack_count", 32'(evt_count), 32'd5);
        chk("fire_ack_evtx", 32'(evt_cogx), 32'd40);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_clr_irq", 32'(irq), 32'd0);
        chk("ack_clr_ovr", 32'(ovr), 32'd0);
        $display("fire+ack sequence done: irq=%0d ovr=%0d", irq, ovr);

        // ---------------- shadow timing while ARMED ----------------
        chk("shadow_pre_state", 32'(state_o), 32'd1);
        frame_valid = 1'b1;
        tick();
        thr_cfg  = 16'h5555;
        sens_cfg = 8'hC3;
        tick();
        chk("thr_midframe", 32'(threshold_o), 32'hAAAA);
        chk("sens_midframe", 32'(sensitivity_o), 32'h5A);
        frame_valid = 1'b0;
        tick();
        chk("thr_eof", 32'(threshold_o), 32'h5555);
        chk("sens_eof", 32'(sensitivity_o), 32'hC3);
        $display("shadow sequence done: threshold_o=%0h", threshold_o);

        // ---------------- disarm together with a hit eof ----------------
        confirm_n = 4'd1;
        frame(1'b1, 1'b0, 1'b1);
        chk("disarm_state", 32'(state_o), 32'd0);
        chk("disarm_irq", 32'(irq), 32'd0);
        chk("disarm_count", 32'(evt_count), 32'd5);
        $display("disarm+hit done: state=%0d irq=%0d", state_o, irq);

        // Idle ignores eof
        frame(1'b1, 1'b0, 1'b0);
        chk("idle_ignore_state", 32'(state_o), 32'd0);
        chk("idle_ignore_count", 32'(evt_count), 32'd5);

        // ---------------- reset in the middle of CONFIRM ----------------
        pulse_arm();
        confirm_n = 4'd3;
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", 32'(state_o), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_count", 32'(evt_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        confirm_n = 4'd1;
        frame(1'b1, 1'b0, 1'b0);
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);
        chk("post_rst_count", 32'(evt_count), 32'd0);
        // Re-armed, the old progress is gone: confirm_n=3 needs three fresh hits.
        pulse_arm();
        confirm_n = 4'd3;
        frame(1'b1, 1'b0, 1'b0);
        chk("rearm_state", 32'(state_o), 32'd2);
        chk("rearm_irq", 32'(irq), 32'd0);
        $display("reset-mid-confirm sequence done: state=%0d", state_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipr1_trig_ctrl.md
IPR1_TRIG_CTRL -- requirements
Module: ipr1_trig_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the event counter.
REQ-002 SHALL have parameters ROI_X1/ROI_X2/ROI_Y1/ROI_Y2, defaults 16/48/16/48, ROI bounds in block units.
REQ-003 SHALL have these ports, one per line as `name  direction  width  meaning`:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- frame_valid  in  1  datapath frame strobe.
- trig_in  in  1  datapath per-frame trigger.
- cogx_i, cogy_i  in  8 each  datapath centre of gravity.
- arm  in  1  one-cycle arm request.
- disarm  in  1  one-cycle disarm request.
- confirm_n  in  4  consecutive hit frames needed to fire.
- holdoff_n  in  8  frames ignored after a fire.
- sens_cfg  in  8  host sensitivity.
- thr_cfg  in  16  host threshold.
- irq_ack  in  1  interrupt acknowledge.
- sensitivity_o  out  8  shadowed sensitivity to datapath.
- threshold_o  out  16  shadowed threshold to datapath.
- irq  out  1  event interrupt, level.
- ovr  out  1  sticky overrun.
- state_o  out  2  FSM state.
- evt_cogx, evt_cogy  out  8 each  latched event location.
- evt_count  out  CNT_W  events fired.

Function
REQ-004 SHALL register frame_valid into fv_d; eof = fv_d & ~frame_valid (one-cycle pulse). All actions SHALL take effect on the edge where eof is high and be visible the next cycle.
REQ-005 SHALL define hit = trig_in when eof, qualified per REQ-021.
REQ-006 SHALL implement the FSM with state_o encoding IDLE=0, ARMED=1, CONFIRM=2, HOLDOFF=3.
REQ-007 disarm SHALL force IDLE from any state and clear hit_cnt and hold_cnt; disarm SHALL win over a simultaneous arm or fire.
REQ-008 IDLE: arm SHALL move to ARMED on the next edge; eof is ignored in IDLE.
REQ-009 ARMED: on hit, set hit_cnt=1; if confirm_n<=1, fire; otherwise go to CONFIRM. On eof without hit, stay.
REQ-010 CONFIRM: on hit, increment hit_cnt and fire when the new hit_cnt >= confirm_n. On eof without hit, return to ARMED with hit_cnt=0.
REQ-011 Fire SHALL:
- latch evt_cogx/evt_cogy from cogx_i/cogy_i;
- increment evt_count, saturating at all-ones;
- set irq=1 and clear hit_cnt;
- load hold_cnt=holdoff_n and go to HOLDOFF, or go to ARMED if holdoff_n==0.
REQ-012 HOLDOFF: on each eof, decrement hold_cnt. When hold_cnt reaches 0, go to ARMED. trig_in SHALL be ignored in HOLDOFF.
REQ-013 irq SHALL stay 1 until a cycle with irq_ack=1 clears it. If fire and irq_ack occur in the same cycle, irq SHALL stay 1.
REQ-014 A fire while irq==1 SHALL set ovr=1; ovr SHALL clear only on irq_ack without a simultaneous fire.
REQ-015 sensitivity_o/threshold_o SHALL load sens_cfg/thr_cfg every cycle in IDLE and only on eof otherwise, so the datapath never sees a mid-frame change.
REQ-016 confirm_n and holdoff_n SHALL be sampled at use; changing them mid-sequence SHALL take effect at the next comparison.

Reset
REQ-017 reset_n low SHALL immediately force state=IDLE, irq=0, ovr=0, evt_cogx=evt_cogy=0, evt_count=0, sensitivity_o=0, threshold_o=0, fv_d=0, hit_cnt=hold_cnt=0.
REQ-018 Reset asserted mid-CONFIRM or mid-HOLDOFF SHALL discard all progress; after release the block SHALL need arm again.
REQ-019 After reset release, the first frame_valid falling edge SHALL produce eof only if fv_d had sampled 1.

Configuration
REQ-020 Macro IPR1_TRIG_ROI_EN SHALL select ROI qualification.
REQ-021 With IPR1_TRIG_ROI_EN defined: hit = eof & trig_in & (ROI_X1<cogx_i<ROI_X2) & (ROI_Y1<cogy_i<ROI_Y2), all comparisons strict. Without it: hit = eof & trig_in.

Verification
REQ-022 Reset, arm, confirm_n=3, holdoff_n=2; trig_in=1 for 3 frames -> irq rises the cycle after the third eof, evt_count=1, state_o=3.
REQ-023 ARMED, confirm_n=3; trig_in pattern 1,1,0,1,1,1 -> only one fire, after the sixth frame.
REQ-024 After a fire with holdoff_n=2: 2 triggered frames ignored; third triggered frame with confirm_n=1 -> second fire; no ack -> ovr=1, irq=1.
REQ-025 thr_cfg changed mid-frame while ARMED -> threshold_o unchanged until the eof cycle; disarm together with a hit eof -> state_o=0, no irq.
REQ-026 With IPR1_TRIG_ROI_EN defined, trig_in=1, cogx_i=16, confirm_n=1 -> no fire; cogx_i=17, cogy_i=30 -> fire, evt_cogx=17.
